vector_op_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational vector unit (8-bit data in; 1-bit, 4-bit and 8-bit results out) among NREQ requesters. It accepts one 8-bit operand at a time and drives it onto the shared unit. It waits a fixed settle time, captures the three results and returns them tagged with the requester index over a valid/ready response channel. The block sits between the requesting logic and the vector unit; the vector unit itself stays outside it.

---
 rtl/vector_op_arbiter.sv | 112 +++++++++++
 tb/tb_vector_op_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_op_arbiter.sv
// Round-robin sequencer sharing one combinational vector unit among NREQ requesters.
// One operand in flight: accept, hold for SETTLE cycles, capture, return tagged response.
module vector_op_arbiter #(
   parameter  int NREQ   = 4,
   parameter  int SETTLE = 1,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [8*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic [7:0]          vec_data,
   input  logic                vec_res1,
   input  logic [3:0]          vec_res2,
   input  logic [0:7]          vec_res3,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic                rsp_res1,
   output logic [3:0]          rsp_res2,
   output logic [0:7]          rsp_res3,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t                 state, state_nx;
   logic [IDW-1:0]         last;
   logic [3:0]             cnt;
   logic [IDW-1:0]         win;
   logic                   found;
   logic [NREQ-1:0][7:0]   ops;

   assign ops = req_data;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   // first valid requester scanning upward from last+1, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req_valid[rr_idx(last, k)]) begin
            found = 1'b1;
            win   = rr_idx(last, k);
         end
      end
   end

   // rst_n gating keeps grants quiet while reset is held
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && found) req_ready[win] = 1'b1;
   end

   assign busy = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (found)          state_nx = DRIVE;
         DRIVE:   if (cnt == 4'd1)    state_nx = RESP;
         RESP:    if (rsp_ready)      state_nx = IDLE;
         default:                     state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last      <= IDW'(NREQ - 1);
         vec_data  <= 8'h00;
         cnt       <= 4'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_res1  <= 1'b0;
         rsp_res2  <= 4'h0;
         rsp_res3  <= 8'h00;
      end else begin
         case (state)
            IDLE: if (found) begin
               vec_data <= ops[win];
               rsp_id   <= win;
               last     <= win;
               cnt      <= 4'(SETTLE);
            end
            DRIVE: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rsp_res1  <= vec_res1;
                  rsp_res2  <= vec_res2;
                  rsp_res3  <= vec_res3;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_op_arbiter.sv
// Bench for vector_op_arbiter: SETTLE=1 instance for arbitration/backpressure/reset,
// SETTLE=3 instance for capture timing; responses scored against a queue.
module tb_vector_op_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic       r1;
      logic [3:0] r2;
      logic [7:0] r3;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // instance a, SETTLE=1
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  vec_data;
   logic        vec_res1;
   logic [3:0]  vec_res2;
   logic [0:7]  vec_res3;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic        rsp_res1;
   logic [3:0]  rsp_res2;
   logic [0:7]  rsp_res3;
   logic        busy;

   // instance b, SETTLE=3
   logic        b_rst_n;
   logic [3:0]  b_req_valid;
   logic [31:0] b_req_data;
   logic [3:0]  b_req_ready;
   logic [7:0]  b_vec;
   logic        b_res1;
   logic [3:0]  b_res2;
   logic [0:7]  b_res3;
   logic        b_rsp_valid, b_rsp_ready;
   logic [1:0]  b_rsp_id;
   logic        b_rsp_res1;
   logic [3:0]  b_rsp_res2;
   logic [0:7]  b_rsp_res3;
   logic        b_busy;
   logic        b_glitch;

   // vector unit models; b's can be corrupted to prove early values are ignored
   assign vec_res1 = ^vec_data;
   assign vec_res2 = vec_data[3:0];
   assign vec_res3 = vec_data;
   assign b_res1   = (^b_vec) ^ b_glitch;
   assign b_res2   = b_vec[3:0] ^ {4{b_glitch}};
   assign b_res3   = b_vec ^ {8{b_glitch}};

   vector_op_arbiter #(.NREQ(4), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .vec_data(vec_data), .vec_res1(vec_res1),
      .vec_res2(vec_res2), .vec_res3(vec_res3), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res1(rsp_res1),
      .rsp_res2(rsp_res2), .rsp_res3(rsp_res3), .busy(busy)
   );

   vector_op_arbiter #(.NREQ(4), .SETTLE(3)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_data(b_req_data),
      .req_ready(b_req_ready), .vec_data(b_vec), .vec_res1(b_res1),
      .vec_res2(b_res2), .vec_res3(b_res3), .rsp_valid(b_rsp_valid),
      .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_res1(b_rsp_res1),
      .rsp_res2(b_rsp_res2), .rsp_res3(b_rsp_res3), .busy(b_busy)
   );

   rsp_t q[$];
   rsp_t b_q[$];
   rsp_t ea, eb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic rsp_t model(input int id, input logic [7:0] d);
      rsp_t r;
      r.id = id[1:0];
      r.r1 = ^d;
      r.r2 = d[3:0];
      r.r3 = d;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (q.size() == 0) chk("a_unexpected_rsp", 32'd1, 32'd0);
         else begin
            ea = q.pop_front();
            chk("a_sb_id", 32'(rsp_id), 32'(ea.id));
            chk("a_sb_res1", 32'(rsp_res1), 32'(ea.r1));
            chk("a_sb_res2", 32'(rsp_res2), 32'(ea.r2));
            chk("a_sb_res3", 32'(rsp_res3), 32'(ea.r3));
         end
      end
   end

   always @(negedge clk) begin
      if (b_rst_n && b_rsp_valid && b_rsp_ready) begin
         if (b_q.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
         else begin
            eb = b_q.pop_front();
            chk("b_sb_id", 32'(b_rsp_id), 32'(eb.id));
            chk("b_sb_res1", 32'(b_rsp_res1), 32'(eb.r1));
            chk("b_sb_res2", 32'(b_rsp_res2), 32'(eb.r2));
            chk("b_sb_res3", 32'(b_rsp_res3), 32'(eb.r3));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int id;
      rst_n = 1'b0; b_rst_n = 1'b0;
      req_valid = 4'b0001; req_data = '0; rsp_ready = 1'b1;
      b_req_valid = '0; b_req_data = '0; b_rsp_ready = 1'b1; b_glitch = 1'b0;
      #2;
      // reset state, with a request held to show grants are gated
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_vec_data", 32'(vec_data), 32'h00);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_res", {19'd0, rsp_res1, rsp_res2, rsp_res3}, 32'd0);
      tick(); tick();
      rst_n = 1'b1; b_rst_n = 1'b1; req_valid = '0;
      tick();

      // single request
      req_data[7:0] = 8'hf3; req_valid = 4'b0001;
      #1 chk("single_grant", 32'(req_ready), 32'b0001);
      q.push_back(model(0, 8'hf3));
      tick();
      req_valid = '0;
      chk("single_vec_data", 32'(vec_data), 32'hf3);
      chk("single_busy", 32'(busy), 32'd1);
      chk("single_no_rsp_yet", 32'(rsp_valid), 32'd0);
      tick();
      chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("single_rsp", {19'd0, rsp_res1, rsp_res2, rsp_res3}, {19'd0, 1'b0, 4'h3, 8'hf3});
      tick();
      chk("single_rsp_done", 32'(rsp_valid), 32'd0);
      chk("single_idle", 32'(busy), 32'd0);

      // all four requesters, two full rounds
      do_reset();
      req_data = {8'hfc, 8'h6d, 8'h55, 8'haa};
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         id = k % 4;
         #1 chk("rr_grant", 32'(req_ready), 32'(1) << id);
         q.push_back(model(id, req_data[8*id +: 8]));
         tick();
         chk("rr_vec_data", 32'(vec_data), 32'(req_data[8*id +: 8]));
         tick();
         chk("rr_rsp_id", 32'(rsp_id), 32'(id));
         if (id == 2) chk("rr_6d_res", {27'd0, rsp_res1, rsp_res2}, {27'd0, 1'b1, 4'hd});
         tick();
      end
      req_valid = '0;

      // backpressure: last=3, req1 alone wins, then all valid while stalled
      req_data[15:8] = 8'h3c; req_valid = 4'b0010; rsp_ready = 1'b0;
      #1 chk("bp_grant", 32'(req_ready), 32'b0010);
      q.push_back(model(1, 8'h3c));
      tick();
      req_valid = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_hold", {21'd0, rsp_id, rsp_res1, rsp_res3}, {21'd0, 2'd1, 1'b0, 8'h3c});
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         tick();
      end
      rsp_ready = 1'b1;
      chk("bp_still_busy", 32'(busy), 32'd1);
      tick();
      chk("bp_idle", 32'(busy), 32'd0);
      chk("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
      chk("bp_next_grant", 32'(req_ready), 32'b0100);
      req_valid = '0;
      tick();

      // wrap-around
      do_reset();
      req_data[7:0] = 8'h11; req_data[31:24] = 8'he7; req_valid = 4'b1001;
      #1 chk("wrap_last3", 32'(req_ready), 32'b0001);
      q.push_back(model(0, 8'h11));
      tick(); tick(); tick();
      chk("wrap_last0", 32'(req_ready), 32'b1000);
      q.push_back(model(3, 8'he7));
      tick();
      req_valid = '0;
      tick(); tick();
      chk("wrap_idle", 32'(busy), 32'd0);

      // asynchronous reset in the middle of DRIVE
      do_reset();
      req_data[7:0] = 8'h9a; req_data[15:8] = 8'h21; req_valid = 4'b0011;
      #1 chk("mid_grant", 32'(req_ready), 32'b0001);
      tick();
      chk("mid_in_drive", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_vec_data", 32'(vec_data), 32'h00);
      chk("mid_req_ready", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      #1 chk("mid_regrant0", 32'(req_ready), 32'b0001);
      q.push_back(model(0, 8'h9a));
      tick(); tick(); tick();
      chk("mid_regrant1", 32'(req_ready), 32'b0010);
      q.push_back(model(1, 8'h21));
      tick();
      req_valid = '0;
      tick(); tick();

      // SETTLE=3: corrupt unit outputs for the first two DRIVE cycles
      b_req_data[23:16] = 8'h55; b_req_valid = 4'b0100; b_glitch = 1'b1;
      #1 chk("b_grant", 32'(b_req_ready), 32'b0100);
      b_q.push_back(model(2, 8'h55));
      tick();
      b_req_valid = '0;
      chk("b_vec_data", 32'(b_vec), 32'h55);
      chk("b_drive1", 32'(b_rsp_valid), 32'd0);
      tick();
      chk("b_drive2", 32'(b_rsp_valid), 32'd0);
      tick();
      b_glitch = 1'b0;
      chk("b_drive3", 32'(b_rsp_valid), 32'd0);
      tick();
      chk("b_capture", 32'(b_rsp_valid), 32'd1);
      chk("b_res", {27'd0, b_rsp_res1, b_rsp_res2}, {27'd0, 1'b0, 4'h5});
      tick();
      chk("b_idle", 32'(b_busy), 32'd0);

      tick();
      chk("a_sb_empty", 32'(q.size()), 32'd0);
      chk("b_sb_empty", 32'(b_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
